store_forward_buffer: RTL and testbench

- Committed-store queue between the MEM stage and data memory.
- Holds up to DEPTH retired stores and drains them to memory through a valid/ready write port.
- Presents its youngest entry as the previous-store operand to the store-load hazard detector.
- When that detector flags a hazard, returns the forwarded data to the load. When any queued store overlaps the load and cannot be forwarded, stalls the load.

---
 rtl/store_forward_buffer_pkg.sv | 23 ++
 rtl/store_forward_buffer_if.sv | 40 ++++
 rtl/store_forward_buffer_store_lane_align.sv | 37 +++
 rtl/store_forward_buffer.sv | 120 ++++++++++++
 tb/tb_store_forward_buffer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_forward_buffer_pkg.sv
// Shared constants and types for the committed-store queue: store instruction IDs,
// byte-enable masks and the queued entry layout.
package store_forward_buffer_pkg;

   localparam logic [5:0] INSTR_SB = 6'd20;
   localparam logic [5:0] INSTR_SH = 6'd21;
   localparam logic [5:0] INSTR_SW = 6'd22;

   localparam logic [3:0] STRB_BYTE = 4'b0001;
   localparam logic [3:0] STRB_HALF = 4'b0011;
   localparam logic [3:0] STRB_WORD = 4'b1111;

   typedef struct packed {
      logic [5:0]  instr_id;
      logic [31:0] addr;
      logic [31:0] data;
   } store_entry_t;

   function automatic logic is_store(input logic [5:0] id);
      return (id == INSTR_SB) || (id == INSTR_SH) || (id == INSTR_SW);
   endfunction

endpackage

// File: rtl/store_forward_buffer_if.sv
// Bundle of the store, hazard/forward and memory-write signals of the store buffer.
// master = surrounding pipeline and memory, slave = the buffer.
interface store_forward_buffer_if #(parameter int DEPTH = 4);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          st_valid;
   logic          st_ready;
   logic [5:0]    st_instr_id;
   logic [31:0]   st_addr;
   logic [31:0]   st_data;
   logic [5:0]    prev_store_instr_id;
   logic [31:0]   prev_store_addr;
   logic          store_load_hazard;
   logic          load_valid;
   logic [31:0]   load_addr;
   logic          fwd_valid;
   logic [31:0]   fwd_data;
   logic          load_stall;
   logic          mem_wr_valid;
   logic          mem_wr_ready;
   logic [31:0]   mem_wr_addr;
   logic [31:0]   mem_wr_data;
   logic [3:0]    mem_wr_strb;
   logic [CW-1:0] count;

   modport master (
      output st_valid, st_instr_id, st_addr, st_data, store_load_hazard,
             load_valid, load_addr, mem_wr_ready,
      input  st_ready, prev_store_instr_id, prev_store_addr, fwd_valid, fwd_data,
             load_stall, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb, count
   );

   modport slave (
      input  st_valid, st_instr_id, st_addr, st_data, store_load_hazard,
             load_valid, load_addr, mem_wr_ready,
      output st_ready, prev_store_instr_id, prev_store_addr, fwd_valid, fwd_data,
             load_stall, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb, count
   );

endinterface

// File: rtl/store_forward_buffer_store_lane_align.sv
// Maps a store entry onto memory byte lanes: byte enables plus lane-replicated data.
// Unknown IDs produce no enables.
module store_lane_align
   import store_forward_buffer_pkg::*;
(
   input  logic [5:0]  instr_id,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [3:0]  strb,
   output logic [31:0] lane_data
);

   // Lane selection by store width; misaligned halfword/word offsets are ignored.
   always_comb begin
      strb      = 4'b0000;
      lane_data = 32'h0000_0000;
      case (instr_id)
         INSTR_SB: begin
            strb      = STRB_BYTE << addr_lo;
            lane_data = {4{data[7:0]}};
         end
         INSTR_SH: begin
            strb      = STRB_HALF << {addr_lo[1], 1'b0};
            lane_data = {2{data[15:0]}};
         end
         INSTR_SW: begin
            strb      = STRB_WORD;
            lane_data = data;
         end
         default: begin
            strb      = 4'b0000;
            lane_data = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/store_forward_buffer.sv
// Committed-store queue between MEM and data memory: drains in order through a
// valid/ready write port, forwards its youngest entry and stalls overlapping loads.
module store_forward_buffer
   import store_forward_buffer_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                 clk,
   input  logic                 rst_n,
   store_forward_buffer_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   store_entry_t  entries_r [DEPTH];
   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;

   logic          not_empty_s;
   logic          not_full_s;
   logic          enq_s;
   logic          deq_s;
   logic          word_hit_s;
   logic          fwd_s;
   logic [PW-1:0] prev_idx_s;
   logic [PW-1:0] slot_off_s;
   store_entry_t  head_entry_s;
   store_entry_t  young_entry_s;
   store_entry_t  new_entry_s;
   logic [3:0]    strb_s;
   logic [31:0]   lane_data_s;

   // Handshake qualifiers; a full buffer refuses stores even when it drains this cycle.
   always_comb begin
      not_empty_s   = (count_r != {CW{1'b0}});
      not_full_s    = (count_r != CW'(DEPTH));
      enq_s         = bus.st_valid && not_full_s && is_store(bus.st_instr_id);
      deq_s         = not_empty_s && bus.mem_wr_ready;
      prev_idx_s    = tail_r - PW'(1);
      head_entry_s  = entries_r[head_r];
      young_entry_s = entries_r[prev_idx_s];
      new_entry_s   = '{instr_id: bus.st_instr_id, addr: bus.st_addr, data: bus.st_data};
   end

   // Word-overlap search across the live slots, measured as distance from head.
   always_comb begin
      word_hit_s = 1'b0;
      slot_off_s = {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         slot_off_s = PW'(i) - head_r;
         word_hit_s = word_hit_s |
                      (({1'b0, slot_off_s} < count_r) &&
                       (entries_r[i].addr[31:2] == bus.load_addr[31:2]));
      end
   end

   store_lane_align u_lane_align (
      .instr_id  (head_entry_s.instr_id),
      .addr_lo   (head_entry_s.addr[1:0]),
      .data      (head_entry_s.data),
      .strb      (strb_s),
      .lane_data (lane_data_s)
   );

   // Output decode; entry-derived outputs are zeroed while empty so stale slots never leak.
   always_comb begin
      fwd_s          = bus.load_valid && bus.store_load_hazard && not_empty_s;
      bus.st_ready   = not_full_s;
      bus.count      = count_r;
      bus.fwd_valid  = fwd_s;
      bus.load_stall = bus.load_valid && !fwd_s && word_hit_s;
      bus.mem_wr_valid = not_empty_s;
      if (not_empty_s) begin
         bus.prev_store_instr_id = young_entry_s.instr_id;
         bus.prev_store_addr     = young_entry_s.addr;
         bus.fwd_data            = young_entry_s.data;
         bus.mem_wr_addr         = {head_entry_s.addr[31:2], 2'b00};
         bus.mem_wr_data         = lane_data_s;
         bus.mem_wr_strb         = strb_s;
      end else begin
         bus.prev_store_instr_id = 6'd0;
         bus.prev_store_addr     = 32'h0000_0000;
         bus.fwd_data            = 32'h0000_0000;
         bus.mem_wr_addr         = 32'h0000_0000;
         bus.mem_wr_data         = 32'h0000_0000;
         bus.mem_wr_strb         = 4'b0000;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         if (enq_s) begin
            tail_r <= tail_r + PW'(1);
         end
         if (deq_s) begin
            head_r <= head_r + PW'(1);
         end
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are only meaningful inside the live window, so no reset.
   always_ff @(posedge clk) begin
      if (enq_s) begin
         entries_r[tail_r] <= new_entry_s;
      end
   end

endmodule

// File: tb/tb_store_forward_buffer.sv
// Directed and randomized bench for store_forward_buffer against a queue-based model
// of the store queue, forwarding and stall rules.
module tb_store_forward_buffer;
   import store_forward_buffer_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [5:0]  id;
      logic [31:0] addr;
      logic [31:0] data;
   } st_t;

   logic clk = 1'b0;
   logic rst_n;
   st_t  q[$];
   int   checks = 0;
   int   failures = 0;
   logic [5:0] ids [4] = '{INSTR_SB, INSTR_SH, INSTR_SW, 6'd1};

   always #5 clk = ~clk;

   store_forward_buffer_if #(.DEPTH(DEPTH)) bus();

   store_forward_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic int width_of(input logic [5:0] id);
      if (id == INSTR_SB) return 1;
      if (id == INSTR_SH) return 2;
      return 4;
   endfunction

   function automatic bit is_st(input logic [5:0] id);
      return (id == INSTR_SB) || (id == INSTR_SH) || (id == INSTR_SW);
   endfunction

   // Expected outputs from the model queue and the current inputs.
   task automatic check_all(input string tag);
      logic [3:0]  e_strb;
      logic [31:0] e_data;
      int          sz;
      int          start;
      bit          e_fwd;
      bit          e_hit;
      chk1({tag, ":st_ready"}, bus.st_ready, q.size() < DEPTH);
      chk({tag, ":count"}, 32'(bus.count), 32'(q.size()));
      chk1({tag, ":mem_wr_valid"}, bus.mem_wr_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk({tag, ":prev_id"}, 32'(bus.prev_store_instr_id), 32'(q[$].id));
         chk({tag, ":prev_addr"}, bus.prev_store_addr, q[$].addr);
         sz    = width_of(q[0].id);
         start = (int'(q[0].addr[1:0]) / sz) * sz;
         for (int k = 0; k < 4; k++) begin
            e_strb[k]        = (k >= start) && (k < start + sz);
            e_data[8*k +: 8] = q[0].data[8*(k % sz) +: 8];
         end
         chk({tag, ":wr_addr"}, bus.mem_wr_addr, q[0].addr & 32'hFFFF_FFFC);
         chk({tag, ":wr_strb"}, 32'(bus.mem_wr_strb), 32'(e_strb));
         chk({tag, ":wr_data"}, bus.mem_wr_data, e_data);
      end else begin
         chk({tag, ":prev_id"}, 32'(bus.prev_store_instr_id), 32'h0);
         chk({tag, ":prev_addr"}, bus.prev_store_addr, 32'h0);
      end
      e_fwd = bus.load_valid && bus.store_load_hazard && (q.size() != 0);
      chk1({tag, ":fwd_valid"}, bus.fwd_valid, e_fwd);
      if (e_fwd) chk({tag, ":fwd_data"}, bus.fwd_data, q[$].data);
      e_hit = 1'b0;
      foreach (q[i]) if (q[i].addr[31:2] == bus.load_addr[31:2]) e_hit = 1'b1;
      chk1({tag, ":load_stall"}, bus.load_stall, bus.load_valid && !e_fwd && e_hit);
   endtask

   // One clock: check at negedge+1, then apply the edge to the model.
   task automatic tick(input string tag);
      bit  enq;
      bit  deq;
      st_t e;
      #1;
      check_all(tag);
      deq    = (q.size() != 0) && bus.mem_wr_ready;
      enq    = bus.st_valid && (q.size() < DEPTH) && is_st(bus.st_instr_id);
      e.id   = bus.st_instr_id;
      e.addr = bus.st_addr;
      e.data = bus.st_data;
      @(posedge clk);
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(e);
      @(negedge clk);
   endtask

   task automatic push(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] data);
      bus.st_valid    = 1'b1;
      bus.st_instr_id = id;
      bus.st_addr     = addr;
      bus.st_data     = data;
   endtask

   task automatic drain();
      bus.st_valid     = 1'b0;
      bus.load_valid   = 1'b0;
      bus.mem_wr_ready = 1'b1;
      for (int n = 0; n < 20 && q.size() != 0; n++) tick("drain");
      #1;
      chk("drain_empty", 32'(bus.count), 32'h0);
   endtask

   initial begin
      rst_n                 = 1'b0;
      bus.st_valid          = 1'b0;
      bus.st_instr_id       = 6'd0;
      bus.st_addr           = 32'h0;
      bus.st_data           = 32'h0;
      bus.store_load_hazard = 1'b0;
      bus.load_valid        = 1'b0;
      bus.load_addr         = 32'h0;
      bus.mem_wr_ready      = 1'b0;
      @(negedge clk);
      #1;
      check_all("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      tick("post_reset");

      // Reset while three stores are queued.
      push(INSTR_SW, 32'h10, 32'h1111_1111); tick("fill_a");
      push(INSTR_SH, 32'h14, 32'h2222_2222); tick("fill_b");
      push(INSTR_SB, 32'h18, 32'h3333_3333); tick("fill_c");
      bus.st_valid = 1'b0;
      #1;
      chk("three_queued", 32'(bus.count), 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("rst_count", 32'(bus.count), 32'h0);
      chk1("rst_wr_valid", bus.mem_wr_valid, 1'b0);
      chk("rst_prev_id", 32'(bus.prev_store_instr_id), 32'h0);
      chk1("rst_st_ready", bus.st_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      tick("rst_release");

      // Byte store at offset 3 lands in the top lane.
      bus.mem_wr_ready = 1'b1;
      push(INSTR_SB, 32'h103, 32'h0000_00AB); tick("sb_enq");
      bus.st_valid = 1'b0;
      #1;
      chk("sb_addr", bus.mem_wr_addr, 32'h100);
      chk("sb_strb", 32'(bus.mem_wr_strb), 32'h8);
      chk("sb_data", bus.mem_wr_data, 32'hABAB_ABAB);
      tick("sb_deq");
      chk("sb_count0", 32'(bus.count), 32'h0);

      // Fill, then a dequeue with a store pending while full.
      bus.mem_wr_ready = 1'b0;
      push(INSTR_SW, 32'h20, 32'hA000_0001); tick("full_0");
      push(INSTR_SH, 32'h26, 32'h0000_BEEF); tick("full_1");
      push(INSTR_SB, 32'h29, 32'h0000_0055); tick("full_2");
      push(INSTR_SW, 32'h2C, 32'hA000_0004); tick("full_3");
      push(INSTR_SW, 32'h30, 32'hA000_0005);
      #1;
      chk1("full_not_ready", bus.st_ready, 1'b0);
      chk("full_count", 32'(bus.count), 32'd4);
      bus.mem_wr_ready = 1'b1;
      tick("full_deq");
      chk("full_after_deq", 32'(bus.count), 32'd3);
      bus.mem_wr_ready = 1'b0;
      push(INSTR_SW, 32'h34, 32'hA000_0006); tick("wrap_enq");
      bus.st_valid = 1'b0;
      #1;
      chk("wrap_prev_addr", bus.prev_store_addr, 32'h34);
      drain();

      // Forward youngest word store.
      bus.mem_wr_ready = 1'b0;
      push(INSTR_SW, 32'h200, 32'hDEAD_BEEF); tick("fwd_enq");
      bus.st_valid          = 1'b0;
      bus.load_valid        = 1'b1;
      bus.load_addr         = 32'h200;
      bus.store_load_hazard = 1'b1;
      #1;
      chk1("fwd_valid", bus.fwd_valid, 1'b1);
      chk("fwd_data", bus.fwd_data, 32'hDEAD_BEEF);
      chk1("fwd_no_stall", bus.load_stall, 1'b0);
      tick("fwd_load");
      bus.store_load_hazard = 1'b0;
      drain();

      // Older overlapping store behind the youngest stalls until drained.
      bus.mem_wr_ready = 1'b0;
      push(INSTR_SW, 32'h300, 32'h0000_0300); tick("old_a");
      push(INSTR_SW, 32'h400, 32'h0000_0400); tick("old_b");
      bus.st_valid   = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_addr  = 32'h300;
      #1;
      chk1("old_stall", bus.load_stall, 1'b1);
      tick("old_hold0");
      tick("old_hold1");
      bus.mem_wr_ready = 1'b1;
      tick("old_drain");
      #1;
      chk1("old_released", bus.load_stall, 1'b0);
      drain();

      // Byte store followed by a word load: no forward, stall.
      bus.mem_wr_ready = 1'b0;
      push(INSTR_SB, 32'h500, 32'h0000_0077); tick("mis_enq");
      bus.st_valid   = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_addr  = 32'h500;
      #1;
      chk1("mis_fwd", bus.fwd_valid, 1'b0);
      chk1("mis_stall", bus.load_stall, 1'b1);
      tick("mis_hold");
      bus.mem_wr_ready = 1'b1;
      tick("mis_drain");
      #1;
      chk1("mis_released", bus.load_stall, 1'b0);
      drain();

      // Ignored non-store ID.
      push(6'd1, 32'h700, 32'h1234_5678); tick("bad_id");
      bus.st_valid = 1'b0;
      #1;
      chk("bad_id_count", 32'(bus.count), 32'h0);

      // Randomized traffic over a small address window.
      for (int n = 0; n < 400; n++) begin
         bus.st_valid          = ($urandom_range(0, 1) == 1);
         bus.st_instr_id       = ids[$urandom_range(0, 3)];
         bus.st_addr           = 32'h600 + 32'($urandom_range(0, 15));
         bus.st_data           = $urandom;
         bus.mem_wr_ready      = ($urandom_range(0, 2) != 0);
         bus.load_valid        = ($urandom_range(0, 1) == 1);
         bus.load_addr         = 32'h600 + 32'($urandom_range(0, 15));
         bus.store_load_hazard = ($urandom_range(0, 1) == 1);
         tick("rand");
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
